// File: rtl/perf_event_monitor.sv
// perf_event_monitor
//   Five saturating performance counters (cycles, retired instructions,
//   stalls, branches, mispredictions) with a single-outstanding read port.
//   A misprediction flush charges FLUSH_PENALTY bubble cycles during which
//   instructions are not counted as retired.
//
// Parameters
//   FLUSH_PENALTY  bubble cycles charged per misprediction flush
//   CNT_W          counter / rd_data width (must be >= 5 to hold status)
//
// Ports
//   clk       single rising-edge clock
//   rst_n     synchronous active-low reset
//   stall_2   pipeline stall this cycle
//   hit_2     branch resolved this cycle
//   rst_out   misprediction flush this cycle
//   cnt_en    counting enable
//   cnt_clr   synchronous clear of counters, bubble counter and ovf flags
//   rd_req    read request (accepted only when the read FSM is idle)
//   rd_addr   counter select: 0 cyc, 1 instret, 2 stall, 3 branch,
//             4 mispred, 5 status, 6/7 read zero
//   rd_ack    response consumed
//   rd_valid  response valid
//   rd_data   response data, held stable while rd_valid is high
//   ovf_irq   sticky overflow indication
//
// Configuration
//   PERF_OVF_IRQ_EN  when defined, per-counter sticky overflow flags are
//                    kept, reported in status[4:0] and ORed onto ovf_irq.
//                    When undefined both are constant zero.
//
// Read FSM
//   state   | meaning
//   IDLE    | waiting for rd_req; rd_addr latched on acceptance
//   CAPTURE | selected counter copied into rd_data on this edge
//   RESP    | rd_valid high, rd_data held until rd_ack

module perf_event_monitor #(
  parameter int FLUSH_PENALTY = 4,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_2,
  input  logic             hit_2,
  input  logic             rst_out,
  input  logic             cnt_en,
  input  logic             cnt_clr,
  input  logic             rd_req,
  input  logic [2:0]       rd_addr,
  input  logic             rd_ack,
  output logic             rd_valid,
  output logic [CNT_W-1:0] rd_data,
  output logic             ovf_irq
);

  localparam int NUM_CNT = 5;
  localparam int IDX_CYC = 0;
  localparam int IDX_INS = 1;
  localparam int IDX_STL = 2;
  localparam int IDX_BRA = 3;
  localparam int IDX_MIS = 4;

  // Zero penalty still needs a legal 1-bit bubble register.
  localparam int BUB_W = (FLUSH_PENALTY < 1) ? 1 : $clog2(FLUSH_PENALTY + 1);
  localparam logic [BUB_W-1:0] BUB_LOAD = BUB_W'(FLUSH_PENALTY);
  localparam logic [BUB_W-1:0] BUB_ONE  = BUB_W'(1);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_PRE = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    RESP    = 2'd2
  } rd_state_t;

  logic [CNT_W-1:0] cnt_q [NUM_CNT];
  logic [NUM_CNT-1:0] inc;
  logic [NUM_CNT-1:0] ovf_q;
  logic [BUB_W-1:0]   bubble_q;

  rd_state_t  state_q;
  rd_state_t  state_d;
  logic       addr_ld;
  logic       data_ld;
  logic [2:0] addr_q;
  logic [CNT_W-1:0] data_q;
  logic [CNT_W-1:0] rd_sel;
  logic [CNT_W-1:0] status;

  // ---------------------------------------------------------------------
  // Increment requests
  // ---------------------------------------------------------------------
  always_comb begin
    inc          = '0;
    inc[IDX_CYC] = cnt_en;
    // Flush cycle and every bubble cycle after it retire nothing.
    inc[IDX_INS] = cnt_en & ~stall_2 & ~rst_out & (bubble_q == '0);
    inc[IDX_STL] = cnt_en & stall_2;
    inc[IDX_BRA] = cnt_en & hit_2;
    inc[IDX_MIS] = cnt_en & rst_out;
  end

  // ---------------------------------------------------------------------
  // Counters and bubble down-counter (clear has priority over increment)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_q[i] <= '0;
      end
      bubble_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (inc[i] && (cnt_q[i] != CNT_MAX)) begin
          cnt_q[i] <= cnt_q[i] + CNT_ONE;
        end
      end
      // A flush inside a bubble window restarts the full penalty.
      if (rst_out) begin
        bubble_q <= BUB_LOAD;
      end else if (bubble_q != '0) begin
        bubble_q <= bubble_q - BUB_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Overflow flags
  // ---------------------------------------------------------------------
`ifdef PERF_OVF_IRQ_EN
  // A flag sets only on the increment that lands on all-ones; a counter
  // already sitting at all-ones cannot re-trigger it.
  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (inc[i] && (cnt_q[i] == CNT_PRE)) begin
          ovf_q[i] <= 1'b1;
        end
      end
    end
  end
`else
  assign ovf_q = '0;
`endif

  assign ovf_irq = |ovf_q;
  assign status  = {{(CNT_W-NUM_CNT){1'b0}}, ovf_q};

  // ---------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_ld  = 1'b0;
    data_ld  = 1'b0;
    rd_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_req) begin
          addr_ld = 1'b1;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        data_ld = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        rd_valid = 1'b1;
        if (rd_ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    rd_sel = '0;
    case (addr_q)
      3'd0:    rd_sel = cnt_q[IDX_CYC];
      3'd1:    rd_sel = cnt_q[IDX_INS];
      3'd2:    rd_sel = cnt_q[IDX_STL];
      3'd3:    rd_sel = cnt_q[IDX_BRA];
      3'd4:    rd_sel = cnt_q[IDX_MIS];
      3'd5:    rd_sel = status;
      default: rd_sel = '0;
    endcase
  end

  // Response data is deliberately outside the cnt_clr path so a clear
  // issued mid-read cannot disturb a captured value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q <= '0;
      data_q <= '0;
    end else begin
      if (addr_ld) begin
        addr_q <= rd_addr;
      end
      if (data_ld) begin
        data_q <= rd_sel;
      end
    end
  end

  assign rd_data = data_q;

endmodule

// File: tb/tb_perf_event_monitor.sv
// tb_perf_event_monitor
//   Directed self-checking bench for perf_event_monitor. A 32-bit instance
//   covers counting, flush bubbles, read timing, clear and reset; an 8-bit
//   instance reaches the saturation point in a few hundred cycles.
//   Build with or without +define+PERF_OVF_IRQ_EN; expectations follow.

module tb_perf_event_monitor;

`ifdef PERF_OVF_IRQ_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        stall_2, hit_2, rst_out, cnt_en, cnt_clr;
  logic        rd_req, rd_ack, rd_valid, ovf_irq;
  logic [2:0]  rd_addr;
  logic [31:0] rd_data;

  logic        s_stall, s_hit, s_flush, s_en, s_clr;
  logic        s_req, s_ack, s_valid, s_irq;
  logic [2:0]  s_addr;
  logic [7:0]  s_data;

  int n_checks = 0;
  int n_errors = 0;

  perf_event_monitor #(.FLUSH_PENALTY(4), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .stall_2(stall_2), .hit_2(hit_2),
    .rst_out(rst_out), .cnt_en(cnt_en), .cnt_clr(cnt_clr),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_valid(rd_valid), .rd_data(rd_data), .ovf_irq(ovf_irq)
  );

  perf_event_monitor #(.FLUSH_PENALTY(4), .CNT_W(8)) dut_s (
    .clk(clk), .rst_n(rst_n), .stall_2(s_stall), .hit_2(s_hit),
    .rst_out(s_flush), .cnt_en(s_en), .cnt_clr(s_clr),
    .rd_req(s_req), .rd_addr(s_addr), .rd_ack(s_ack),
    .rd_valid(s_valid), .rd_data(s_data), .ovf_irq(s_irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full handshake on the 32-bit instance with latency checks.
  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    rd_req  = 1'b1;
    rd_addr = a;
    tick();
    rd_req = 1'b0;
    check("rd_valid_n1", {31'd0, rd_valid}, 32'd0);
    tick();
    check("rd_valid_n2", {31'd0, rd_valid}, 32'd1);
    d = rd_data;
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    check("rd_valid_ack", {31'd0, rd_valid}, 32'd0);
  endtask

  task automatic rd_chk(input logic [2:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] d;
    rd(a, d);
    check(tag, d, exp);
  endtask

  task automatic s_rd(input logic [2:0] a, output logic [31:0] d);
    s_req  = 1'b1;
    s_addr = a;
    tick();
    s_req = 1'b0;
    tick();
    check("s_rd_valid", {31'd0, s_valid}, 32'd1);
    d = {24'd0, s_data};
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0;
  endtask

  task automatic clr();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  logic [31:0] d;
  logic [31:0] exp_ev [8];

  initial begin
    {stall_2, hit_2, rst_out, cnt_en, cnt_clr, rd_req, rd_ack} = '0;
    rd_addr = '0;
    {s_stall, s_hit, s_flush, s_en, s_clr, s_req, s_ack} = '0;
    s_addr = '0;
    rst_n  = 1'b0;
    tick();
    tick();
    check("rst_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_data", rd_data, 32'd0);
    check("rst_irq", {31'd0, ovf_irq}, 32'd0);
    rst_n = 1'b1;

    // 100 event-free enabled cycles
    cnt_en = 1'b1;
    repeat (100) tick();
    cnt_en = 1'b0;
    check("idle_data", rd_data, 32'd0);
    rd_chk(3'd0, 32'd100, "cyc_100");
    rd_chk(3'd1, 32'd100, "instret_100");

    // Single flush over 20 cycles
    clr();
    cnt_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rst_out = (i == 3);
      tick();
    end
    rst_out = 1'b0;
    cnt_en  = 1'b0;
    rd_chk(3'd0, 32'd20, "flush1_cyc");
    rd_chk(3'd1, 32'd15, "flush1_instret");
    rd_chk(3'd4, 32'd1, "flush1_mispred");

    // Flush on cycles 0 and 2: bubble reload, 7 cycles excluded
    clr();
    cnt_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rst_out = (i == 0) || (i == 2);
      tick();
    end
    rst_out = 1'b0;
    cnt_en  = 1'b0;
    rd_chk(3'd1, 32'd13, "flush2_instret");
    rd_chk(3'd4, 32'd2, "flush2_mispred");

    // Mixed events; stall on cycle 7 lands inside the bubble window
    clr();
    cnt_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      stall_2 = (i == 1) || (i == 2) || (i == 7);
      hit_2   = (i == 2) || (i == 5);
      rst_out = (i == 5);
      tick();
    end
    {stall_2, hit_2, rst_out, cnt_en} = '0;
    exp_ev = '{32'd10, 32'd3, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0, 32'd0};
    for (int a = 0; a < 8; a++) begin
      rd_chk(3'(a), exp_ev[a], $sformatf("mix_addr%0d", a));
    end

    // Clear wins over a same-cycle increment
    cnt_en  = 1'b1;
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    rd_chk(3'd0, 32'd0, "clr_priority");

    // Read in flight while counting; clear and second request during RESP
    clr();
    cnt_en = 1'b1;
    repeat (10) tick();
    rd_req  = 1'b1;
    rd_addr = 3'd0;
    tick();
    rd_req = 1'b0;
    check("inflight_n1", {31'd0, rd_valid}, 32'd0);
    tick();
    check("inflight_n2", {31'd0, rd_valid}, 32'd1);
    check("inflight_data", rd_data, 32'd11);
    for (int i = 0; i < 5; i++) begin
      cnt_clr = (i == 1);
      if (i == 3) begin
        rd_req  = 1'b1;
        rd_addr = 3'd2;
      end
      tick();
      cnt_clr = 1'b0;
      rd_req  = 1'b0;
      check($sformatf("hold_valid%0d", i), {31'd0, rd_valid}, 32'd1);
      check($sformatf("hold_data%0d", i), rd_data, 32'd11);
    end
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    check("ack_drop", {31'd0, rd_valid}, 32'd0);
    tick();
    check("no_queue1", {31'd0, rd_valid}, 32'd0);
    tick();
    check("no_queue2", {31'd0, rd_valid}, 32'd0);
    cnt_en = 1'b0;
    rd_chk(3'd0, 32'd6, "cyc_after_midclr");

    // Saturation on the 8-bit instance: stall preloaded to 0xFE, then 3 more
    s_en    = 1'b1;
    s_stall = 1'b1;
    repeat (254) tick();
    check("s_pre_irq", {31'd0, s_irq}, 32'd0);
    repeat (3) tick();
    s_en    = 1'b0;
    s_stall = 1'b0;
    s_rd(3'd2, d);
    check("s_stall_sat", d, 32'h0000_00FF);
    s_rd(3'd0, d);
    check("s_cyc_sat", d, 32'h0000_00FF);
    s_rd(3'd1, d);
    check("s_instret", d, 32'd0);
    s_rd(3'd5, d);
    check("s_status", d, OVF_ON ? 32'h05 : 32'h00);
    check("s_irq", {31'd0, s_irq}, {31'd0, OVF_ON});
    s_clr = 1'b1;
    tick();
    s_clr = 1'b0;
    check("s_irq_clr", {31'd0, s_irq}, 32'd0);
    s_rd(3'd2, d);
    check("s_stall_clr", d, 32'd0);

    // Reset while the response is pending
    clr();
    cnt_en  = 1'b1;
    stall_2 = 1'b1;
    repeat (5) tick();
    cnt_en  = 1'b0;
    stall_2 = 1'b0;
    rd_req  = 1'b1;
    rd_addr = 3'd2;
    tick();
    rd_req = 1'b0;
    tick();
    check("pre_rst_valid", {31'd0, rd_valid}, 32'd1);
    check("pre_rst_data", rd_data, 32'd5);
    rst_n = 1'b0;
    tick();
    check("rst_resp_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_resp_data", rd_data, 32'd0);
    rst_n = 1'b1;
    for (int a = 0; a < 5; a++) begin
      rd_chk(3'(a), 32'd0, $sformatf("post_rst_addr%0d", a));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/perf_event_monitor.md
PERF_EVENT_MONITOR -- requirements
Module: perf_event_monitor

Interface
REQ-001 SHALL have parameter FLUSH_PENALTY, default 4, meaning the number of pipeline-bubble cycles charged per misprediction flush.
REQ-002 SHALL have parameter CNT_W, default 32, meaning the width of each counter and of rd_data.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port stall_2, input, 1, pipeline stall event for the current cycle.
REQ-006 SHALL have port hit_2, input, 1, branch resolved this cycle.
REQ-007 SHALL have port rst_out, input, 1, misprediction flush this cycle.
REQ-008 SHALL have port cnt_en, input, 1, counting enable.
REQ-009 SHALL have port cnt_clr, input, 1, synchronous clear of all counters.
REQ-010 SHALL have port rd_req, input, 1, read request.
REQ-011 SHALL have port rd_addr, input, 3, counter select.
REQ-012 SHALL have port rd_ack, input, 1, response consumed.
REQ-013 SHALL have port rd_valid, output, 1, response valid.
REQ-014 SHALL have port rd_data, output, CNT_W, response data.
REQ-015 SHALL have port ovf_irq, output, 1, sticky overflow indication.

Function
REQ-016 Counters SHALL be cyc, instret, stall, branch and mispred, each CNT_W bits.
REQ-017 When cnt_en=1, cyc SHALL +1 every cycle; stall SHALL +1 when stall_2=1; branch SHALL +1 when hit_2=1; mispred SHALL +1 when rst_out=1.
REQ-018 A bubble down-counter SHALL load FLUSH_PENALTY on rst_out=1 (reload when already nonzero) and otherwise decrement to 0.
REQ-019 instret SHALL +1 only when cnt_en=1, stall_2=0, rst_out=0 and bubble=0; a stall during a bubble SHALL still count in stall.
REQ-020 All counters SHALL saturate at all-ones and SHALL NOT wrap.
REQ-021 cnt_clr=1 SHALL zero all counters, the bubble counter and ovf_irq next cycle, and SHALL take priority over increments in the same cycle.
REQ-022 The read FSM SHALL have states IDLE, CAPTURE and RESP.
REQ-023 In IDLE, rd_req=1 SHALL latch rd_addr and go to CAPTURE; in CAPTURE, the selected value SHALL be copied into rd_data and the FSM SHALL go to RESP.
REQ-024 In RESP, rd_valid=1 and rd_data SHALL be held stable until rd_ack=1; rd_ack=1 SHALL return the FSM to IDLE.
REQ-025 rd_valid SHALL rise exactly 2 cycles after the rd_req sample edge; rd_req outside IDLE SHALL be ignored and not queued.
REQ-026 Address map: 0=cyc, 1=instret, 2=stall, 3=branch, 4=mispred, 5=status {ovf flags of counters 4..0 in bits 4:0, zero-extended}, 6 and 7 SHALL read 0.
REQ-027 Counting SHALL continue while a read is in flight; the read SHALL return the value present at the CAPTURE edge.
REQ-028 cnt_clr during CAPTURE or RESP SHALL NOT alter the held rd_data.

Reset
REQ-029 rst_n=0 at a clock edge SHALL zero all counters, the bubble counter, ovf flags, rd_data, rd_valid and ovf_irq, and SHALL force IDLE, including mid-read (the response is dropped).
REQ-030 Outputs SHALL be 0 from the first edge with rst_n=0 until the first valid read.

Configuration
REQ-031 Macro PERF_OVF_IRQ_EN: when defined, a per-counter sticky ovf flag SHALL set on the increment that reaches all-ones, and ovf_irq SHALL be the OR of the flags, cleared only by reset or cnt_clr.
REQ-032 Without PERF_OVF_IRQ_EN, ovf_irq and status bits 4:0 SHALL be constant 0.

Verification
REQ-033 After reset, cnt_en=1 for 100 cycles with no events; read addr 0 -> rd_data=100, read addr 1 -> rd_data=100.
REQ-034 One rst_out pulse with FLUSH_PENALTY=4 over 20 cycles -> mispred=1, instret=15 (flush cycle plus 4 bubbles excluded), cyc=20.
REQ-035 rst_out on cycles 0 and 2 -> bubble reloads and instret excludes 7 cycles total.
REQ-036 Preload the stall counter to 0xFFFFFFFE, then 3 stall cycles -> stall=0xFFFFFFFF; with the macro defined, ovf_irq=1 and status=0x04; without it, ovf_irq=0.
REQ-037 rd_req at edge N -> rd_valid=1 at edge N+2; hold rd_ack=0 for 5 cycles -> rd_data unchanged; rd_ack=1 -> rd_valid=0 next cycle; a second rd_req during RESP is ignored.
REQ-038 rst_n=0 during RESP -> rd_valid=0 next edge and all counters read 0.
